// File: rtl/wb_sram_bist_pkg.sv
// wb_sram_bist_pkg: shared state encoding, bus constants and the BIST data pattern.
// The inverse-pass states exist only when WB_SRAM_BIST_INV_PASS_EN is defined.
package wb_sram_bist_pkg;

    localparam logic [31:0] WORD_STRIDE = 32'd4;
    localparam logic [3:0]  SEL_ALL     = 4'hF;

    typedef enum logic [3:0] {
        S_IDLE, S_WR_REQ, S_WR_GAP, S_RD_REQ, S_RD_CHK, S_FIN
`ifdef WB_SRAM_BIST_INV_PASS_EN
        , S_IWR_REQ, S_IWR_GAP, S_IRD_REQ, S_IRD_CHK
`endif
    } state_e;

    function automatic logic [31:0] pattern(input logic [31:0] seed, input logic [15:0] idx);
        return seed ^ {~idx, idx};
    endfunction

endpackage

// File: rtl/wb_sram_bist_watchdog.sv
// wb_sram_bist_watchdog: counts cycles a strobe waits for ack; expired is high on the last allowed cycle.
module wb_sram_bist_watchdog #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);
    localparam int W = $clog2(TIMEOUT_CYCLES);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_cnt <= '0;
        else          r_cnt <= (i_clr || !i_en) ? '0 : r_cnt + W'(1);
    end

    assign o_expired = i_en && (r_cnt == W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/wb_sram_bist_master.sv
// wb_sram_bist_master: Wishbone classic BIST initiator; writes pattern(i) over a word range, reads it back, compares.
// Define WB_SRAM_BIST_INV_PASS_EN to append a second write/read pass using the inverted pattern.
module wb_sram_bist_master
    import wb_sram_bist_pkg::*;
#(
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int ERR_W          = 16
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic              start_i,
    input  logic [31:0]       base_adr_i,
    input  logic [CNT_W-1:0]  word_count_i,
    input  logic [31:0]       seed_i,
    output logic              wbm_cyc_o,
    output logic              wbm_stb_o,
    output logic              wbm_we_o,
    output logic [3:0]        wbm_sel_o,
    output logic [31:0]       wbm_adr_o,
    output logic [31:0]       wbm_dat_o,
    input  logic              wbm_ack_i,
    input  logic [31:0]       wbm_dat_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic              timeout_o,
    output logic [ERR_W-1:0]  err_count_o,
    output logic [31:0]       first_fail_adr_o
);
    state_e             r_state, w_next;
    logic [31:0]        r_base, r_seed, r_rdat, r_ff;
    logic [CNT_W-1:0]   r_cnt, r_idx;
    logic [ERR_W-1:0]   r_err;
    logic               r_timeout, r_pass;
    logic               w_wr_req, w_rd_req, w_gap, w_chk, w_inv;
    logic               w_stb, w_last, w_expired, w_start, w_mismatch;
    logic [31:0]        w_adr, w_pat;

`ifdef WB_SRAM_BIST_INV_PASS_EN
    assign w_wr_req = r_state inside {S_WR_REQ, S_IWR_REQ};
    assign w_rd_req = r_state inside {S_RD_REQ, S_IRD_REQ};
    assign w_gap    = r_state inside {S_WR_GAP, S_IWR_GAP};
    assign w_chk    = r_state inside {S_RD_CHK, S_IRD_CHK};
    assign w_inv    = r_state inside {S_IWR_REQ, S_IWR_GAP, S_IRD_REQ, S_IRD_CHK};
`else
    assign w_wr_req = r_state == S_WR_REQ;
    assign w_rd_req = r_state == S_RD_REQ;
    assign w_gap    = r_state == S_WR_GAP;
    assign w_chk    = r_state == S_RD_CHK;
    assign w_inv    = 1'b0;
`endif

    assign w_stb      = w_wr_req || w_rd_req;
    assign w_last     = r_idx == r_cnt - CNT_W'(1);
    assign w_adr      = r_base + 32'(r_idx) * WORD_STRIDE;
    assign w_pat      = pattern(r_seed, 16'(r_idx)) ^ {32{w_inv}};
    assign w_start    = (r_state == S_IDLE) && start_i;
    assign w_mismatch = w_chk && (r_rdat != w_pat);

    // Bus outputs decode straight from state so an async reset drops cyc/stb at once.
    assign wbm_cyc_o        = w_stb;
    assign wbm_stb_o        = w_stb;
    assign wbm_we_o         = w_wr_req;
    assign wbm_sel_o        = w_stb ? SEL_ALL : 4'h0;
    assign wbm_adr_o        = w_stb ? w_adr : '0;
    assign wbm_dat_o        = w_wr_req ? w_pat : '0;
    assign busy_o           = !(r_state inside {S_IDLE, S_FIN});
    assign done_o           = r_state == S_FIN;
    assign pass_o           = done_o ? (r_err == '0 && !r_timeout) : r_pass;
    assign timeout_o        = r_timeout;
    assign err_count_o      = r_err;
    assign first_fail_adr_o = r_ff;

    wb_sram_bist_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
        .i_clk     (wb_clk_i),
        .i_rst_n   (wb_rst_ni),
        .i_clr     (wbm_ack_i),
        .i_en      (w_stb),
        .o_expired (w_expired)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (start_i) w_next = (word_count_i == '0) ? S_FIN : S_WR_REQ;
            S_WR_REQ:  w_next = wbm_ack_i ? S_WR_GAP : w_expired ? S_FIN : S_WR_REQ;
            S_WR_GAP:  w_next = w_last ? S_RD_REQ : S_WR_REQ;
            S_RD_REQ:  w_next = wbm_ack_i ? S_RD_CHK : w_expired ? S_FIN : S_RD_REQ;
`ifdef WB_SRAM_BIST_INV_PASS_EN
            S_RD_CHK:  w_next = w_last ? S_IWR_REQ : S_RD_REQ;
            S_IWR_REQ: w_next = wbm_ack_i ? S_IWR_GAP : w_expired ? S_FIN : S_IWR_REQ;
            S_IWR_GAP: w_next = w_last ? S_IRD_REQ : S_IWR_REQ;
            S_IRD_REQ: w_next = wbm_ack_i ? S_IRD_CHK : w_expired ? S_FIN : S_IRD_REQ;
            S_IRD_CHK: w_next = w_last ? S_FIN : S_IRD_REQ;
`else
            S_RD_CHK:  w_next = w_last ? S_FIN : S_RD_REQ;
`endif
            S_FIN:     w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state   <= S_IDLE;
            r_base    <= '0;
            r_seed    <= '0;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_rdat    <= '0;
            r_err     <= '0;
            r_ff      <= '0;
            r_timeout <= 1'b0;
            r_pass    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_base    <= base_adr_i & ~32'h3;
                r_cnt     <= word_count_i;
                r_seed    <= seed_i;
                r_idx     <= '0;
                r_err     <= '0;
                r_ff      <= '0;
                r_timeout <= 1'b0;
                r_pass    <= 1'b0;
            end
            if (w_gap || w_chk) r_idx <= w_last ? '0 : r_idx + CNT_W'(1);
            if (w_rd_req && wbm_ack_i) r_rdat <= wbm_dat_i;
            if (w_mismatch) begin
                if (r_err == '0) r_ff <= w_adr;
                if (r_err != '1) r_err <= r_err + ERR_W'(1);
            end
            if (w_stb && !wbm_ack_i && w_expired) r_timeout <= 1'b1;
            if (done_o) r_pass <= pass_o;
        end
    end

endmodule

// File: tb/tb_wb_sram_bist_master.sv
// tb_wb_sram_bist_master: SRAM responder plus a transfer-list model of the BIST; every bus cycle is checked
// against the model, and each test pins a few hand-computed results.
module tb_wb_sram_bist_master;

    localparam int TO = 64;
`ifdef WB_SRAM_BIST_INV_PASS_EN
    localparam int PASSES = 2;
`else
    localparam int PASSES = 1;
`endif

    logic        clk, rst_n, start;
    logic [31:0] base_adr, seed;
    logic [15:0] word_count;
    logic        cyc, stb, we, ack;
    logic [3:0]  sel;
    logic [31:0] adr, dat_o, dat_i;
    logic        busy, done, pass, timeout;
    logic [15:0] err_count;
    logic [31:0] first_fail;

    wb_sram_bist_master #(.CNT_W(16), .TIMEOUT_CYCLES(TO), .ERR_W(16)) dut (
        .wb_clk_i        (clk),
        .wb_rst_ni       (rst_n),
        .start_i         (start),
        .base_adr_i      (base_adr),
        .word_count_i    (word_count),
        .seed_i          (seed),
        .wbm_cyc_o       (cyc),
        .wbm_stb_o       (stb),
        .wbm_we_o        (we),
        .wbm_sel_o       (sel),
        .wbm_adr_o       (adr),
        .wbm_dat_o       (dat_o),
        .wbm_ack_i       (ack),
        .wbm_dat_i       (dat_i),
        .busy_o          (busy),
        .done_o          (done),
        .pass_o          (pass),
        .timeout_o       (timeout),
        .err_count_o     (err_count),
        .first_fail_adr_o(first_fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM responder: ack after lat wait cycles, optional bit-0 corruption on reads of bad_adr
    logic [31:0] mem [64];
    int          wait_cnt = 0;
    int          lat = 0;
    logic        ack_en = 1'b1, stray = 1'b0, bad_en = 1'b0;
    logic [31:0] bad_adr = '0;

    assign ack   = stray || (cyc && stb && ack_en && wait_cnt >= lat);
    assign dat_i = mem[adr[7:2]] ^ {31'b0, (bad_en && !we && adr == bad_adr)};

    always @(posedge clk) begin
        wait_cnt <= (cyc && stb && !ack) ? wait_cnt + 1 : 0;
        if (cyc && stb && we && ack) mem[adr[7:2]] <= dat_o;
    end

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
    } xfer_t;

    xfer_t       q[$];
    int          errors = 0, checks = 0;
    int          m_err, stb_run = 0;
    logic [31:0] m_ff, first_dat, first_adr;
    logic        m_to, prev_ack = 1'b0;
    int          t_lat;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected transfer list: per pass, all writes then all reads, pattern inverted on the second pass
    task automatic plan(input logic [31:0] b, input int n, input logic [31:0] s);
        xfer_t x;
        int    i16;
        q.delete();
        m_err = 0;
        m_ff  = '0;
        m_to  = 1'b0;
        for (int p = 0; p < PASSES; p++)
            for (int w = 0; w < 2; w++)
                for (int i = 0; i < n; i++) begin
                    i16   = i % 65536;
                    x.we  = (w == 0);
                    x.adr = (b & ~32'h3) + 32'(4 * i);
                    x.dat = s ^ 32'(((65535 - i16) * 65536) + i16);
                    if (p == 1) x.dat = ~x.dat;
                    q.push_back(x);
                end
    endtask

    task automatic mon();
        if (!rst_n) begin
            prev_ack = 1'b0;
            stb_run  = 0;
            return;
        end
        if (cyc || stb) begin
            chk("cyc_eq_stb", stb, cyc);
            chk("gap_after_ack", prev_ack, 0);
            if (q.size() == 0) chk("unexpected_cyc", cyc, 0);
            else begin
                chk("we", we, q[0].we);
                chk("adr", adr, q[0].adr);
                chk("sel", sel, 4'hF);
                if (q[0].we) chk("wdat", dat_o, q[0].dat);
                if (ack) begin
                    if (!q[0].we && dat_i != q[0].dat) begin
                        if (m_err == 0) m_ff = q[0].adr;
                        m_err++;
                    end
                    void'(q.pop_front());
                    stb_run = 0;
                end else begin
                    stb_run++;
                    if (stb_run == TO) begin
                        m_to = 1'b1;
                        q.delete();
                        stb_run = 0;
                    end
                end
            end
        end
        prev_ack = cyc && ack;
    endtask

    task automatic tick();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
    endtask

    function automatic int xfer_lat(input int n);
        return 2 * n * PASSES * (lat + 2);
    endfunction

    task automatic run(input logic [31:0] b, input int n, input logic [31:0] s, input int exp_lat,
                       input bit inject, output int t);
        logic mp;
        base_adr   = b;
        word_count = 16'(n);
        seed       = s;
        start      = 1'b1;
        tick();
        start     = 1'b0;
        first_dat = dat_o;
        first_adr = adr;
        if (n > 0) chk("busy_running", busy, 1);
        t = 0;
        while (!done && t < 5000) begin
            if (inject && t == 3) begin
                start      = 1'b1;
                word_count = 16'd1;
                seed       = '0;
            end else start = 1'b0;
            tick();
            t++;
        end
        mp = (m_err == 0) && !m_to;
        chk("done_seen", done, 1);
        chk("done_lat", t, exp_lat);
        chk("err_count", err_count, m_err);
        chk("first_fail", first_fail, m_ff);
        chk("timeout", timeout, m_to);
        chk("pass", pass, mp);
        chk("busy_at_done", busy, 0);
        chk("xfers_left", q.size(), 0);
        tick();
        chk("done_pulse", done, 0);
        chk("pass_hold", pass, mp);
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        base_adr   = '0;
        word_count = '0;
        seed       = '0;
        #2;
        chk("rst_ctrl", {cyc, stb, we, sel, busy, done, pass, timeout}, 0);
        chk("rst_err", err_count, 0);
        chk("rst_ff", first_fail, 0);
        chk("rst_adr", adr, 0);
        chk("rst_dat", dat_o, 0);
        tick();
        tick();
        rst_n = 1'b1;
        stray = 1'b1;
        tick();
        tick();
        chk("stray_ack_idle", {cyc, busy, done}, 0);
        stray = 1'b0;

        // zero-wait, clean
        plan(32'h3000_0000, 8, 32'hA5A5_0000);
        chk("model_wr0", q[0].dat, 32'h5A5A_0000);
        run(32'h3000_0000, 8, 32'hA5A5_0000, xfer_lat(8), 1'b0, t_lat);
        chk("t1_wr0_dat", first_dat, 32'h5A5A_0000);
        chk("t1_wr0_adr", first_adr, 32'h3000_0000);
        chk("t1_lat_lit", t_lat, 32 * PASSES);
        chk("t1_pass_lit", pass, 1);
        chk("t1_err_lit", err_count, 0);

        // read of word 5 corrupted
        bad_en  = 1'b1;
        bad_adr = 32'h3000_0014;
        plan(32'h3000_0000, 8, 32'hA5A5_0000);
        run(32'h3000_0000, 8, 32'hA5A5_0000, xfer_lat(8), 1'b0, t_lat);
        chk("t2_err_lit", err_count, PASSES);
        chk("t2_ff_lit", first_fail, 32'h3000_0014);
        chk("t2_pass_lit", pass, 0);
        bad_en = 1'b0;

        // no ack ever
        ack_en = 1'b0;
        plan(32'h3000_0000, 8, 32'hA5A5_0000);
        run(32'h3000_0000, 8, 32'hA5A5_0000, TO, 1'b0, t_lat);
        chk("t3_model_to", m_to, 1);
        chk("t3_timeout_lit", timeout, 1);
        chk("t3_pass_lit", pass, 0);
        ack_en = 1'b1;

        // empty range
        plan(32'h3000_0000, 0, 32'hA5A5_0000);
        run(32'h3000_0000, 0, 32'hA5A5_0000, 0, 1'b0, t_lat);
        chk("t4_pass_lit", pass, 1);
        chk("t4_timeout_cleared", timeout, 0);

        // two wait states, unaligned base wrapping past 2^32, start pulsed while busy
        lat = 2;
        plan(32'hFFFF_FFFB, 4, 32'h1234_5678);
        run(32'hFFFF_FFFB, 4, 32'h1234_5678, xfer_lat(4), 1'b1, t_lat);
        chk("t5_wr0_adr", first_adr, 32'hFFFF_FFF8);
        chk("t5_wr0_dat", first_dat, 32'hEDCB_5678);
        chk("t5_pass_lit", pass, 1);
        lat = 0;

        // async reset during read 3, then a clean rerun
        plan(32'h3000_0000, 8, 32'hA5A5_0000);
        base_adr   = 32'h3000_0000;
        word_count = 16'd8;
        seed       = 32'hA5A5_0000;
        start      = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < 200 && !(cyc && !we && adr == 32'h3000_000C); n++) tick();
        chk("t6_rd3_reached", {cyc, we, adr}, {1'b1, 1'b0, 32'h3000_000C});
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_cyc_stb_busy", {cyc, stb, busy}, 0);
        q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        chk("t6_post_rst", {cyc, busy, done, pass, timeout}, 0);
        plan(32'h3000_0000, 8, 32'hA5A5_0000);
        run(32'h3000_0000, 8, 32'hA5A5_0000, xfer_lat(8), 1'b0, t_lat);
        chk("t6_pass_lit", pass, 1);

`ifdef WB_SRAM_BIST_INV_PASS_EN
        plan(32'h3000_0000, 4, 32'hA5A5_0000);
        chk("t7_model_xfers", q.size(), 16);
        chk("t7_model_inv_wr0", q[8].dat, 32'hA5A5_FFFF);
        run(32'h3000_0000, 4, 32'hA5A5_0000, xfer_lat(4), 1'b0, t_lat);
        chk("t7_lat_lit", t_lat, 32);
        chk("t7_pass_lit", pass, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_sram_bist_master.md
Name: wb_sram_bist_master

Overview:
- Wishbone classic initiator that drives the user project's Wishbone slave port to test the SRAMs behind it.
- Writes a deterministic pattern over a programmed word range, then reads the range back and compares.
- Reports pass/fail, the mismatch count and the first failing address.
- Sits on the Caravel side of the bus, in place of the management SoC, in test harnesses and in the on-chip self-test path.

Parameters:
- CNT_W, 16, width of word count and word index.
- TIMEOUT_CYCLES, 64, cycles without ack before a transfer aborts; minimum 2.
- ERR_W, 16, width of the saturating mismatch counter.

Ports:
- wb_clk_i  in  1  the single clock.
- wb_rst_ni  in  1  reset, asynchronous, active-low.
- start_i  in  1  one-cycle pulse; sampled only in IDLE.
- base_adr_i  in  32  byte address of word 0; bits [1:0] are ignored (treated as 0).
- word_count_i  in  CNT_W  number of 32-bit words to test.
- seed_i  in  32  pattern seed.
- wbm_cyc_o  out  1  Wishbone cycle.
- wbm_stb_o  out  1  Wishbone strobe.
- wbm_we_o  out  1  Wishbone write enable.
- wbm_sel_o  out  4  byte selects; always 4'hF during a transfer.
- wbm_adr_o  out  32  Wishbone address.
- wbm_dat_o  out  32  Wishbone write data.
- wbm_ack_i  in  1  Wishbone acknowledge.
- wbm_dat_i  in  32  Wishbone read data.
- busy_o  out  1  test in progress.
- done_o  out  1  one-cycle pulse when the test ends.
- pass_o  out  1  valid from done_o until the next start: no mismatch and no timeout.
- timeout_o  out  1  sticky until the next start; a transfer exceeded TIMEOUT_CYCLES.
- err_count_o  out  ERR_W  saturating mismatch count.
- first_fail_adr_o  out  32  address of the first mismatch; 0 if none.

Behaviour:
- Reset (asynchronous, wb_rst_ni low): all outputs 0, FSM enters IDLE.
  - Reset asserted mid-transfer drops cyc/stb immediately.
- Pattern for word i: pattern(i) = seed_i XOR {~i[15:0], i[15:0]}, with i zero-extended or truncated to 16 bits.
- Address for word i: base_adr_i + 4*i, 32-bit wrap-around allowed.
- On start_i in IDLE, capture base, count and seed; clear err_count, first_fail, timeout and pass; set busy.
- FSM states:
  - IDLE: wait for start_i.
  - WR_REQ: cyc=stb=we=1, hold adr/dat stable until ack.
  - WR_GAP: cyc=stb=0 for exactly one cycle; i++; go to RD_REQ with i=0 after the last word, else WR_REQ.
  - RD_REQ: cyc=stb=1, we=0, until ack.
  - RD_CHK: one cycle; compare the wbm_dat_i value registered at ack against pattern(i).
    - On mismatch: err_count++ (saturating at all-ones); capture first_fail on the first mismatch only.
    - Then i++; go to FIN after the last word, else RD_REQ.
  - FIN: done_o=1 for one cycle, busy=0, pass_o = (err_count==0 && !timeout); go to IDLE.
- Each transfer takes ack-latency + 1 cycles plus one gap cycle. With zero-wait ack (ack in the first stb cycle) a transfer takes 2 cycles.
- Timeout: a counter runs while stb is high. When it reaches TIMEOUT_CYCLES:
  - deassert cyc/stb, set timeout_o, go to FIN (pass_o=0).
- word_count_i == 0: go straight to FIN on the next cycle, pass_o=1, no bus activity.
- start_i while busy: ignored.
- wbm_ack_i outside a transfer: ignored.
- wbm_dat_i is sampled only on the ack cycle of a read.

Optional Feature:
- Macro WB_SRAM_BIST_INV_PASS_EN.
- Defined: after the read pass, run a second write + read pass using ~pattern(i). Failures accumulate in the same counter and first_fail register. FIN follows the second read pass.
- Undefined: a single pattern pass only, and the inverse-pass states are not built.

Decomposition:
- Package wb_sram_bist_pkg holds:
  - the state enum (IDLE, WR_REQ, WR_GAP, RD_REQ, RD_CHK, FIN, plus inverse-pass states when enabled);
  - the pattern() function;
  - the WORD_STRIDE = 4 constant;
  - SEL_ALL = 4'hF.
- One sub-module: wb_sram_bist_watchdog, the TIMEOUT_CYCLES counter with clear/enable and an expired output.

Test Plan:
- Zero-wait responder (SRAM model), base=0x3000_0000, count=8, seed=0xA5A5_0000 -> 8 writes then 8 reads.
  - Write 0 data = 0xA5A5_0000 ^ 0xFFFF_0000 = 0x5A5A_0000.
  - done after 32 cycles, pass=1, err_count=0.
- Same setup, responder corrupts the read at word 5 (flip bit 0) -> err_count=1, first_fail=0x3000_0014, pass=0.
- Responder never acks, TIMEOUT_CYCLES=64 -> stb high for 64 cycles, then cyc/stb drop; timeout=1, done pulse, pass=0.
- count=0 -> no cyc assertion, done one cycle after start, pass=1.
- Reset pulled low during read 3 -> cyc/stb/busy go 0 in the same cycle. A new start then reruns cleanly with pass=1.
- With WB_SRAM_BIST_INV_PASS_EN, count=4 -> 16 transfers; second-pass write 0 data = 0xA5A5_FFFF; pass=1.
